id_ex_pipe: RTL and testbench

Parametrised ID/EX pipeline stage: a two-entry elastic register (main + skid) carrying operands A/B, register addresses rd/rs/rt and a control word from decode to execute. It uses a valid/ready handshake on both sides, a synchronous flush, and load-use hazard detection that blocks acceptance and inserts one bubble. It sits between the register-file read in ID and the ALU/forwarding logic in EX, and replaces the fixed 32-bit, handshake-free ID/EX latch.

---
 rtl/id_ex_pipe.sv | 159 +++++++++++++++
 tb/tb_id_ex_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline stage: two-entry elastic buffer (main + skid) with valid/ready
// handshakes, synchronous flush, load-use hazard blocking and a saturating stall counter.
module id_ex_pipe #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int CTRL_W      = 8,
    parameter int MEMREAD_BIT = 0,
    parameter int CNT_W       = 16
) (
    input  logic              reloj,
    input  logic              resetID,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] DOA,
    input  logic [DATA_W-1:0] DOB,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [CTRL_W-1:0] ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [REG_AW-1:0] rd_o,
    output logic [REG_AW-1:0] rs_o,
    output logic [REG_AW-1:0] rt_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              hazard_o,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    occ_t             state_reg;
    occ_t             state_next;
    entry_t           m_reg;
    entry_t           s_reg;
    entry_t           in_entry;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic m_valid;
    logic s_valid;
    logic accept;
    logic pop;
    logic hazard;
    logic m_load_in;
    logic m_load_s;
    logic s_load;

    assign in_entry = {ctrl, rt, rs, rd, DOB, DOA};
    assign m_valid  = (state_reg != EMPTY);
    assign s_valid  = (state_reg == FULL);

    // Only the entry in EX (main) can be a load whose result is not yet available.
    assign hazard = in_valid & m_valid & m_reg.ctrl[MEMREAD_BIT]
                  & (m_reg.rd != '0)
                  & ((m_reg.rd == rs) | (m_reg.rd == rt));

    assign in_ready = ~s_valid & ~hazard;
    assign accept   = in_valid & in_ready;
    assign pop      = m_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        m_load_in  = 1'b0;
        m_load_s   = 1'b0;
        s_load     = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        m_load_in  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        m_load_in = 1'b1;
                    end else if (accept) begin
                        state_next = FULL;
                        s_load     = 1'b1;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next = ONE;
                        m_load_s   = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge reloj or negedge resetID) begin
        if (!resetID) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Payload registers only move on a transfer; flush leaves them untouched.
    always_ff @(posedge reloj or negedge resetID) begin
        if (!resetID) begin
            m_reg <= '0;
            s_reg <= '0;
        end else begin
            if (m_load_in) begin
                m_reg <= in_entry;
            end else if (m_load_s) begin
                m_reg <= s_reg;
            end
            if (s_load) begin
                s_reg <= in_entry;
            end
        end
    end

    always_ff @(posedge reloj or negedge resetID) begin
        if (!resetID) begin
            stall_cnt_reg <= '0;
        end else if (hazard && !flush && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
        end
    end

    assign out_valid = m_valid;
    assign A         = m_reg.a;
    assign B         = m_reg.b;
    assign rd_o      = m_reg.rd;
    assign rs_o      = m_reg.rs;
    assign rt_o      = m_reg.rt;
    assign ctrl_o    = m_reg.ctrl;
    assign hazard_o  = hazard;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed vector table, hand-written reset and
// saturation sequences, and a randomized run against a queue-based reference model.
module tb_id_ex_pipe;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] doa;
    logic [31:0] dob;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [7:0]  ctrl;

    logic        in_ready, out_valid, hazard_o;
    logic [31:0] a_o, b_o;
    logic [4:0]  rd_o, rs_o, rt_o;
    logic [7:0]  ctrl_o;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2, hazard2;
    logic [31:0] a2, b2;
    logic [4:0]  rd2, rs2, rt2;
    logic [7:0]  ctrl2;
    logic [1:0]  stall2;

    id_ex_pipe dut (
        .reloj(clk), .resetID(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .DOA(doa), .DOB(dob), .rd(rd), .rs(rs), .rt(rt), .ctrl(ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(a_o), .B(b_o), .rd_o(rd_o), .rs_o(rs_o), .rt_o(rt_o), .ctrl_o(ctrl_o),
        .hazard_o(hazard_o), .stall_cnt(stall_cnt)
    );

    id_ex_pipe #(.CNT_W(2)) dut_sat (
        .reloj(clk), .resetID(rst2_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .DOA(doa), .DOB(dob), .rd(rd), .rs(rs), .rt(rt), .ctrl(ctrl),
        .out_valid(out_valid2), .out_ready(out_ready),
        .A(a2), .B(b2), .rd_o(rd2), .rs_o(rs2), .rt_o(rt2), .ctrl_o(ctrl2),
        .hazard_o(hazard2), .stall_cnt(stall2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [31:0] a,
                         input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                         input logic [7:0] c);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        doa       = a;
        dob       = ~a;
        rd        = d;
        rs        = s;
        rt        = t;
        ctrl      = c;
    endtask

    typedef struct {
        logic        iv, ordy, fl;
        logic [31:0] a;
        logic [4:0]  rd, rs, rt;
        logic        ld;
        logic        e_irdy, e_haz;   // before the edge
        logic        e_ov;            // after the edge
        logic [31:0] e_a;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic ordy, input logic fl, input logic [31:0] a,
                       input logic [4:0] d, input logic [4:0] s, input logic [4:0] t, input logic ld,
                       input logic e_irdy, input logic e_haz, input logic e_ov,
                       input logic [31:0] e_a, input logic [15:0] e_cnt);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.a = a;
        v.rd = d; v.rs = s; v.rt = t; v.ld = ld;
        v.e_irdy = e_irdy; v.e_haz = e_haz; v.e_ov = e_ov; v.e_a = e_a; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [4:0]  rt, rs, rd;
        logic [31:0] b, a;
    } ent_t;

    ent_t        q[$];
    ent_t        disp;
    ent_t        cur;
    logic [15:0] m_cnt;
    logic        m_haz, m_irdy, m_acc, m_pop;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n  = 1'b0;
        rst2_n = 1'b0;

        // streaming: A=i, rd=i back to back
        for (int i = 0; i < 8; i++) add(1, 1, 0, i, i[4:0], 0, 0, 0, 1, 0, 1, i, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 0);
        // backpressure for three cycles, then release
        add(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(1, 0, 0, 2, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        add(1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 1, 3, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        // load-use: load rd=5, dependent rs=5 stalls, bubble, then accepted
        add(1, 0, 0, 32'h50, 5, 0, 0, 1, 1, 0, 1, 32'h50, 0);
        add(1, 1, 0, 32'h60, 7, 5, 1, 0, 0, 1, 0, 32'h50, 1);
        add(1, 1, 0, 32'h60, 7, 5, 1, 0, 1, 0, 1, 32'h60, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h60, 1);
        // no hazard: load to rd=0, non-load in M, load rd=5 vs rs=rt=6
        add(1, 0, 0, 32'h70, 0, 0, 0, 1, 1, 0, 1, 32'h70, 1);
        add(1, 1, 0, 32'h71, 1, 0, 0, 0, 1, 0, 1, 32'h71, 1);
        add(1, 1, 0, 32'h72, 5, 2, 3, 1, 1, 0, 1, 32'h72, 1);
        add(1, 1, 0, 32'h73, 2, 6, 6, 0, 1, 0, 1, 32'h73, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h73, 1);
        // flush from FULL with in_valid, then flush discarding an accept
        add(1, 0, 0, 32'h81, 0, 0, 0, 0, 1, 0, 1, 32'h81, 1);
        add(1, 0, 0, 32'h82, 0, 0, 0, 0, 1, 0, 1, 32'h81, 1);
        add(1, 0, 1, 32'h83, 0, 0, 0, 0, 0, 0, 0, 32'h81, 1);
        add(1, 0, 1, 32'h84, 0, 0, 0, 0, 1, 0, 0, 32'h81, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h81, 1);

        // reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_A", a_o, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].a, tbl[i].rd, tbl[i].rs, tbl[i].rt,
                  {7'd0, tbl[i].ld});
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_irdy);
            chk($sformatf("vec%0d_hazard", i), hazard_o, tbl[i].e_haz);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("vec%0d_A", i), a_o, tbl[i].e_a);
            chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, tbl[i].e_cnt);
            $display("vec %0d: iv=%0d ordy=%0d fl=%0d a=%0h -> ov=%0d A=%0h rdy=%0d haz=%0d cnt=%0d",
                     i, tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].a, out_valid, a_o,
                     in_ready, hazard_o, stall_cnt);
        end

        // reset mid-stream while FULL with 0x11 / 0x22
        @(negedge clk);
        drive(1, 0, 0, 32'h11, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 32'h22, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("full_A", a_o, 32'h11);
        chk("full_in_ready", in_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_A", a_o, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_stall_cnt", stall_cnt, 0);
        chk("async_rst_hazard", hazard_o, 0);
        $display("reset mid-stream: ov=%0d A=%0h rdy=%0d cnt=%0d", out_valid, a_o, in_ready, stall_cnt);
        @(negedge clk);
        rst_n = 1'b1;

        // saturation on the 2-bit counter instance
        rst2_n = 1'b1;
        drive(1, 0, 0, 32'h5, 5, 0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(1, 0, 0, 32'h6, 1, 5, 0, 0);
            #1;
            chk($sformatf("sat%0d_hazard", k), hazard2, 1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d_stall_cnt", k), stall2, (k < 2) ? k + 1 : 3);
            $display("sat cycle %0d: hazard=%0d stall_cnt=%0d", k, hazard2, stall2);
        end

        // randomized run against the queue model
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        disp  = '0;
        m_cnt = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                  $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 8'($urandom));
            cur   = {ctrl, rt, rs, rd, dob, doa};
            m_haz = in_valid && (q.size() > 0) && q[0].ctrl[0] && (q[0].rd != 0)
                    && (q[0].rd == rs || q[0].rd == rt);
            m_irdy = (q.size() < 2) && !m_haz;
            #1;
            chk($sformatf("rnd%0d_hazard", c), hazard_o, m_haz);
            chk($sformatf("rnd%0d_in_ready", c), in_ready, m_irdy);
            chk($sformatf("rnd%0d_out_valid", c), out_valid, q.size() > 0);
            chk($sformatf("rnd%0d_fields", c), {ctrl_o, rt_o, rs_o, rd_o, b_o, a_o}, disp);
            chk($sformatf("rnd%0d_stall_cnt", c), stall_cnt, m_cnt);
            if (m_haz && !flush && m_cnt != 16'hFFFF) m_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                m_pop = (q.size() > 0) && out_ready;
                m_acc = in_valid && m_irdy;
                if (m_pop) begin
                    $display("rnd %0d: pop A=%0h rd=%0d ctrl=%0h", c, q[0].a, q[0].rd, q[0].ctrl);
                    void'(q.pop_front());
                end
                if (m_acc) q.push_back(cur);
            end
            if (q.size() > 0) disp = q[0];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
